// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: credit accumulation, multi-item vend, serial change/refund.
// Latency: every output is registered; a response appears the cycle after the causing input edge.
// Backpressure: change coins advance only on change_valid_o && change_ready_i; while the hopper
//   stalls, the offered code is held and new coins are rejected.
// Ports: clk_i/reset_i (async, active-high); coin_i, vend_req_i, item_i, cancel_i, change_ready_i in;
//   dispense_o, item_o, change_valid_o, change_coin_o, credit_o, coin_reject_o, insufficient_o, busy_o out.
module vend_ctrl_param #(
  parameter int NUM_ITEMS  = 4,
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 20,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES = {5'd10, 5'd8, 5'd6, 5'd4},
  localparam int ITEM_W    = $clog2(NUM_ITEMS)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [2:0]          coin_i,
  input  logic                vend_req_i,
  input  logic [ITEM_W-1:0]   item_i,
  input  logic                cancel_i,
  input  logic                change_ready_i,
  output logic                dispense_o,
  output logic [ITEM_W-1:0]   item_o,
  output logic                change_valid_o,
  output logic [1:0]          change_coin_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                coin_reject_o,
  output logic                insufficient_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {S_COLLECT, S_VEND, S_CHANGE} state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_dispense;
  logic [ITEM_W-1:0]   r_item;
  logic                r_change_valid;
  logic [1:0]          r_change_coin;
  logic                r_reject;
  logic                r_insuf;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic [ITEM_W-1:0]   w_item_nxt;
  logic                w_reject_nxt;
  logic                w_insuf_nxt;
  logic [CREDIT_W-1:0] w_coin_val;
  logic                w_coin_onehot;
  logic [CREDIT_W-1:0] w_coin_add;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_price;
  logic                w_item_ok;

  // Largest coin not exceeding the remaining credit: quarter, dime, nickel.
  function automatic logic [1:0] greedy_code(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(5))      return 2'b11;
    else if (c >= CREDIT_W'(2)) return 2'b10;
    else if (c != '0)           return 2'b01;
    else                        return 2'b00;
  endfunction

  function automatic logic [CREDIT_W-1:0] code_value(input logic [1:0] code);
    case (code)
      2'b01:   return CREDIT_W'(1);
      2'b10:   return CREDIT_W'(2);
      2'b11:   return CREDIT_W'(5);
      default: return '0;
    endcase
  endfunction

  always_comb begin
    w_state_nxt   = r_state;
    w_credit_nxt  = r_credit;
    w_item_nxt    = '0;
    w_reject_nxt  = 1'b0;
    w_insuf_nxt   = 1'b0;
    w_coin_val    = '0;
    w_coin_onehot = 1'b0;
    w_coin_add    = '0;
    w_sum         = '0;
    w_price       = '0;
    w_item_ok     = 1'b0;

    case (coin_i)
      3'b001:  begin w_coin_val = CREDIT_W'(1); w_coin_onehot = 1'b1; end
      3'b010:  begin w_coin_val = CREDIT_W'(2); w_coin_onehot = 1'b1; end
      3'b100:  begin w_coin_val = CREDIT_W'(5); w_coin_onehot = 1'b1; end
      default: begin w_coin_val = '0;           w_coin_onehot = 1'b0; end
    endcase

    // Out-of-range selections (possible when NUM_ITEMS is not a power of two) leave w_item_ok low.
    for (int k = 0; k < NUM_ITEMS; k++) begin
      if (item_i == k[ITEM_W-1:0]) begin
        w_price   = PRICES[k*CREDIT_W +: CREDIT_W];
        w_item_ok = 1'b1;
      end
    end

    case (r_state)
      S_COLLECT: begin
        // One extra bit so the ceiling check can never wrap.
        w_sum = {1'b0, r_credit} + {1'b0, w_coin_val};
        if (coin_i != 3'b000) begin
          if (!w_coin_onehot || (w_sum > (CREDIT_W+1)'(MAX_CREDIT))) w_reject_nxt = 1'b1;
          else                                                       w_coin_add   = w_coin_val;
        end
        w_credit_nxt = r_credit + w_coin_add;
        if (cancel_i) begin
          // Refund includes a coin accepted in the same cycle.
          if (w_credit_nxt != '0) w_state_nxt = S_CHANGE;
        end else if (vend_req_i) begin
          // Affordability is judged on the credit held before this cycle's coin.
          if (!w_item_ok || (r_credit < w_price)) begin
            w_insuf_nxt = 1'b1;
          end else begin
            w_credit_nxt = r_credit + w_coin_add - w_price;
            w_state_nxt  = S_VEND;
            w_item_nxt   = item_i;
          end
        end
      end
      S_VEND: begin
        w_reject_nxt = (coin_i != 3'b000);
        w_state_nxt  = (r_credit != '0) ? S_CHANGE : S_COLLECT;
      end
      S_CHANGE: begin
        w_reject_nxt = (coin_i != 3'b000);
        if (change_ready_i) begin
          w_credit_nxt = r_credit - code_value(r_change_coin);
          if (w_credit_nxt == '0) w_state_nxt = S_COLLECT;
        end
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state        <= S_COLLECT;
      r_credit       <= '0;
      r_dispense     <= 1'b0;
      r_item         <= '0;
      r_change_valid <= 1'b0;
      r_change_coin  <= 2'b00;
      r_reject       <= 1'b0;
      r_insuf        <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_credit       <= w_credit_nxt;
      r_dispense     <= (w_state_nxt == S_VEND);
      r_item         <= w_item_nxt;
      r_change_valid <= (w_state_nxt == S_CHANGE);
      // While stalled the credit is unchanged, so the recomputed code is the held one.
      r_change_coin  <= (w_state_nxt == S_CHANGE) ? greedy_code(w_credit_nxt) : 2'b00;
      r_reject       <= w_reject_nxt;
      r_insuf        <= w_insuf_nxt;
      r_busy         <= (w_state_nxt != S_COLLECT);
    end
  end

  assign dispense_o     = r_dispense;
  assign item_o         = r_item;
  assign change_valid_o = r_change_valid;
  assign change_coin_o  = r_change_coin;
  assign credit_o       = r_credit;
  assign coin_reject_o  = r_reject;
  assign insufficient_o = r_insuf;
  assign busy_o         = r_busy;

endmodule
